// File: rtl/approx_pkg.sv
// Shared definitions for the approximate-product accumulator.
package approx_pkg;

  localparam int PROD_W_DEF = 16;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Accumulator width: a full frame of max products can never overflow.
  function automatic int acc_width(input int prod_w, input int len_w);
    return prod_w + len_w;
  endfunction

endpackage

// File: rtl/approx_prod_accumulator.sv
// Streaming accumulator: sums a programmed number of approximate products
// from the inexact multiplier upstream into one frame result.
module approx_prod_accumulator
  import approx_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int ACC_W  = acc_width(PROD_W, LEN_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [ACC_W-1:0]  sum
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [ACC_W-1:0]   acc_nxt;
  logic               prod_hs;
  logic               last_hs;

  // A product landing in an abort cycle is dropped.
  assign prod_hs = (state_q == ACC) & prod_valid & ~abort;
  assign last_hs = prod_hs & (rem_q == LEN_W'(1));
  assign acc_nxt = acc_q + ACC_W'(prod);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort wins over start and over completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!abort && start) state_d = (len != '0) ? ACC : DONE;
      ACC: begin
        if (abort)        state_d = IDLE;
        else if (last_hs) state_d = DONE;
      end
      DONE: if (abort || sum_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded purely from state
  always_comb begin
    busy       = 1'b0;
    prod_ready = 1'b0;
    sum_valid  = 1'b0;
    case (state_q)
      ACC: begin
        busy       = 1'b1;
        prod_ready = 1'b1;
      end
      DONE: begin
        busy      = 1'b1;
        sum_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state: frame setup, accumulation, result capture
  always_comb begin
    acc_d = acc_q;
    rem_d = rem_q;
    sum_d = sum_q;
    if (state_q == IDLE && start && !abort) begin
      acc_d = '0;
      rem_d = len;
      if (len == '0) sum_d = '0;
    end else if (prod_hs) begin
      acc_d = acc_nxt;
      rem_d = rem_q - LEN_W'(1);
      if (last_hs) sum_d = acc_nxt;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      rem_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      rem_q <= rem_d;
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_approx_prod_accumulator.sv
// Self-checking bench for approx_prod_accumulator with a result scoreboard.
module tb_approx_prod_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic        prod_valid = 1'b0;
  logic        prod_ready;
  logic [15:0] prod = '0;
  logic        sum_valid;
  logic        sum_ready = 1'b1;
  logic [23:0] sum;

  int tests = 0;
  int fails = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_sum;
  logic [15:0] prods[256];

  approx_prod_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .busy(busy), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .prod(prod), .sum_valid(sum_valid), .sum_ready(sum_ready), .sum(sum)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every delivered sum must match the oldest expected value
  always @(negedge clk) begin
    if (rst_n && sum_valid && sum_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_sum got %0d with nothing expected", sum);
      end else begin
        exp_sum = exp_q.pop_front();
        if (sum !== exp_sum) begin
          fails++;
          $display("FAIL scoreboard_sum got %0d expected %0d", sum, exp_sum);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a frame and push the model sum of prods[0..n-1]
  task automatic begin_frame(input int n);
    logic [23:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s = s + 24'(prods[i]);
    exp_q.push_back(s);
    start = 1'b1;
    len   = 8'(n);
    tick();
    start = 1'b0;
    len   = '0;
  endtask

  // Feed prods[0..n-1] back to back
  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      prod_valid = 1'b1;
      prod       = prods[i];
      tick();
    end
    prod_valid = 1'b0;
    prod       = '0;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({busy, prod_ready, sum_valid} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ctrl got %b expected 000", {busy, prod_ready, sum_valid});
    end
    tests++;
    if (sum !== 24'd0) begin
      fails++;
      $display("FAIL reset_sum got %0d expected 0", sum);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    prods[0] = 16'd100; prods[1] = 16'd200; prods[2] = 16'd65535;
    sum_ready = 1'b0;
    begin_frame(3);
    tests++;
    if (prod_ready !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_acc_ready got %b%b expected 11", prod_ready, busy);
    end
    feed(3);
    tests++;
    if (sum_valid !== 1'b1 || prod_ready !== 1'b0 || sum !== 24'd65835) begin
      fails++;
      $display("FAIL basic_done got v=%b r=%b sum=%0d expected v=1 r=0 sum=65835",
               sum_valid, prod_ready, sum);
    end
    sum_ready = 1'b1;
    tick();
    tests++;
    if (sum_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle got v=%b busy=%b expected 0 0", sum_valid, busy);
    end
    tick();
  endtask

  task automatic test_bubbles();
    logic [6:0] pat;
    int hs;
    int k;
    pat = 7'b1011001;  // bit i = valid at step i: 1,0,0,1,1,0,1
    hs = 0;
    k  = 0;
    for (int i = 0; i < 4; i++) prods[i] = 16'(i + 1);
    begin_frame(4);
    for (int i = 0; i < 7; i++) begin
      prod_valid = pat[i];
      prod       = 16'(k + 1);
      #1;
      if (prod_valid && prod_ready) begin
        hs++;
        k++;
      end
      tick();
    end
    prod_valid = 1'b0;
    tests++;
    if (hs != 4) begin
      fails++;
      $display("FAIL bubble_handshakes got %0d expected 4", hs);
    end
    tests++;
    if (prod_ready !== 1'b0 || sum_valid !== 1'b1) begin
      fails++;
      $display("FAIL bubble_done got r=%b v=%b expected r=0 v=1", prod_ready, sum_valid);
    end
    tick();
    tick();
  endtask

  task automatic test_len0();
    begin_frame(0);
    tests++;
    if (sum_valid !== 1'b1 || prod_ready !== 1'b0 || sum !== 24'd0) begin
      fails++;
      $display("FAIL len0_done got v=%b r=%b sum=%0d expected v=1 r=0 sum=0",
               sum_valid, prod_ready, sum);
    end
    tick();
    tests++;
    if (prod_ready !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL len0_idle got r=%b busy=%b expected 0 0", prod_ready, busy);
    end
    tick();
  endtask

  task automatic test_len255();
    bit seen;
    for (int i = 0; i < 255; i++) prods[i] = 16'hFFFF;
    sum_ready = 1'b0;
    begin_frame(255);
    feed(255);
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      if (sum_valid) seen = 1'b1;
      else tick();
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL len255_timeout got no sum_valid expected sum_valid within 4 cycles");
    end
    tests++;
    if (sum !== 24'hFEFF01) begin
      fails++;
      $display("FAIL len255_sum got %h expected feff01", sum);
    end
    sum_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_hold_abort();
    prods[0] = 16'd1; prods[1] = 16'd2; prods[2] = 16'd3;
    sum_ready = 1'b0;
    begin_frame(3);
    feed(3);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      len   = 8'd2;
      tick();
      tests++;
      if (sum_valid !== 1'b1 || sum !== 24'd6 || prod_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_stable cycle %0d got v=%b sum=%0d r=%b expected v=1 sum=6 r=0",
                 c, sum_valid, sum, prod_ready);
      end
    end
    start = 1'b0;
    len   = '0;
    sum_ready = 1'b1;
    tick();
    tests++;
    if (busy !== 1'b0 || sum_valid !== 1'b0) begin
      fails++;
      $display("FAIL hold_release got busy=%b v=%b expected 0 0", busy, sum_valid);
    end
    tick();
    // Abort after two of five products; the third lands with abort and is dropped
    start = 1'b1;
    len   = 8'd5;
    tick();
    start = 1'b0;
    prods[0] = 16'd9; prods[1] = 16'd9;
    feed(2);
    prod_valid = 1'b1;
    prod       = 16'd9;
    abort      = 1'b1;
    tick();
    abort      = 1'b0;
    prod_valid = 1'b0;
    tests++;
    if ({busy, prod_ready, sum_valid} !== 3'b000) begin
      fails++;
      $display("FAIL abort_idle got %b expected 000", {busy, prod_ready, sum_valid});
    end
    for (int c = 0; c < 4; c++) tick();
    prods[0] = 16'd7;
    begin_frame(1);
    feed(1);
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    len   = 8'd3;
    tick();
    start = 1'b0;
    prods[0] = 16'd50;
    feed(1);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, prod_ready, sum_valid} !== 3'b000) begin
      fails++;
      $display("FAIL async_reset got %b expected 000", {busy, prod_ready, sum_valid});
    end
    tick();
    rst_n = 1'b1;
    tick();
    prods[0] = 16'd5; prods[1] = 16'd6;
    begin_frame(2);
    feed(2);
    tests++;
    if (sum_valid !== 1'b1 || sum !== 24'd11) begin
      fails++;
      $display("FAIL post_reset got v=%b sum=%0d expected v=1 sum=11", sum_valid, sum);
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_len0();
    test_len255();
    test_hold_abort();
    test_async_reset();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
